// File: rtl/gray_pkg.sv
// Shared types and default sizes for gray-coded count consumers.
package gray_pkg;

  localparam int GRAY_W_DEF      = 4;
  localparam int GRAY_ERR_W_DEF  = 8;
  localparam int GRAY_LOSS_DEF   = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } gray_chk_state_t;

  typedef enum logic [1:0] {
    STEP_REPEAT  = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } gray_step_t;

endpackage

// File: rtl/gray2bin.sv
// Combinational gray-to-binary decode: each binary bit is the XOR of all
// gray bits at or above it.
module gray2bin #(
  parameter int WIDTH = gray_pkg::GRAY_W_DEF
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_decoder_checker.sv
// Decodes a gray count stream, checks each sample is a legal single step and
// tracks lock. Define GRAY_DEC_BIDIR_EN to accept down steps and expose dir.
module gray_decoder_checker
  import gray_pkg::*;
#(
  parameter int WIDTH       = GRAY_W_DEF,
  parameter int ERR_W       = GRAY_ERR_W_DEF,
  parameter int LOSS_THRESH = GRAY_LOSS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count,
`ifdef GRAY_DEC_BIDIR_EN
  output logic             dir,
`endif
  output logic             locked
);

  localparam int CW = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH + 1) : 1;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [CW-1:0]    LAST_MISS = CW'(LOSS_THRESH - 1);

  gray_chk_state_t  state;
  logic [WIDTH-1:0] ref_bin;
  logic [CW-1:0]    consec;
  logic [WIDTH-1:0] dec_bin;
  logic [WIDTH-1:0] up_bin;
  logic [WIDTH-1:0] dn_bin;
  gray_step_t       step;

  gray2bin #(.WIDTH(WIDTH)) u_dec (
    .gray (gray_in),
    .bin  (dec_bin)
  );

  // Modular arithmetic makes the max->0 and 0->max wraps fall out naturally.
  assign up_bin = ref_bin + ONE;
  assign dn_bin = ref_bin - ONE;

  always_comb begin
    step = STEP_ILLEGAL;
    if (dec_bin == ref_bin)
      step = STEP_REPEAT;
    else if (dec_bin == up_bin)
      step = STEP_UP;
`ifdef GRAY_DEC_BIDIR_EN
    else if (dec_bin == dn_bin)
      step = STEP_DOWN;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ref_bin   <= '0;
      consec    <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      step_err  <= 1'b0;
      err_count <= '0;
      locked    <= 1'b0;
`ifdef GRAY_DEC_BIDIR_EN
      dir       <= 1'b0;
`endif
    end else begin
      bin_valid <= 1'b0;
      step_err  <= 1'b0;
      if (gray_valid) begin
        bin_out   <= dec_bin;
        bin_valid <= 1'b1;
        ref_bin   <= dec_bin;  // resync even on an illegal step
        case (state)
          IDLE: begin
            state  <= LOCKED;
            locked <= 1'b1;
            consec <= '0;
          end
          LOCKED: begin
            if (step == STEP_ILLEGAL) begin
              step_err <= 1'b1;
              if (err_count != {ERR_W{1'b1}})
                err_count <= err_count + ERR_W'(1);
              if (consec == LAST_MISS) begin
                state  <= IDLE;
                locked <= 1'b0;
                consec <= '0;
              end else begin
                consec <= consec + CW'(1);
              end
            end else begin
              consec <= '0;
`ifdef GRAY_DEC_BIDIR_EN
              if (step == STEP_UP)   dir <= 1'b1;
              if (step == STEP_DOWN) dir <= 1'b0;
`endif
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // dn_bin only feeds the bidirectional compare.
`ifndef GRAY_DEC_BIDIR_EN
  logic unused_dn;
  assign unused_dn = ^dn_bin;
`endif

endmodule

// File: tb/tb_gray_decoder_checker.sv
// Directed bench for gray_decoder_checker at WIDTH=4, ERR_W=8, LOSS_THRESH=3.
module tb_gray_decoder_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gray_in = 4'd0;
  logic       gray_valid = 1'b0;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       step_err;
  logic [7:0] err_count;
  logic       locked;
`ifdef GRAY_DEC_BIDIR_EN
  logic       dir;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // {bin_out, bin_valid, step_err, locked, err_count}
  logic [14:0] obs;
  assign obs = {bin_out, bin_valid, step_err, locked, err_count};

  gray_decoder_checker #(.WIDTH(4), .ERR_W(8), .LOSS_THRESH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .gray_in    (gray_in),
    .gray_valid (gray_valid),
    .bin_out    (bin_out),
    .bin_valid  (bin_valid),
    .step_err   (step_err),
    .err_count  (err_count),
`ifdef GRAY_DEC_BIDIR_EN
    .dir        (dir),
`endif
    .locked     (locked)
  );

  always #5 clk = ~clk;

  logic [3:0] gray_seq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  task automatic send(input logic [3:0] g);
    @(negedge clk);
    gray_in    = g;
    gray_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    @(negedge clk);
    gray_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    gray_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] exp;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp = 15'd0;
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs, exp);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_count();
    logic [14:0] exp;
    for (int i = 0; i < 16; i++) begin
      send(gray_seq[i]);
      exp = {4'(i), 1'b1, 1'b0, 1'b1, 8'd0};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL count_seq[%0d]: got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [14:0] exp;
    send(4'b0000);
    exp = {4'd0, 1'b1, 1'b0, 1'b1, 8'd0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL wrap_15_to_0: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_step_error();
    logic [14:0] exp;
    send(4'b0001);
    send(4'b0010);
    exp = {4'd3, 1'b1, 1'b1, 1'b1, 8'd1};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL skip_1_to_3: got %h want %h", obs, exp);
    end
    gap();
    exp = {4'd3, 1'b0, 1'b0, 1'b1, 8'd1};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL err_pulse_width: got %h want %h", obs, exp);
    end
    send(4'b0110);
    exp = {4'd4, 1'b1, 1'b0, 1'b1, 8'd1};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL resync_3_to_4: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_loss();
    logic [14:0] exp;
    send(4'b0000);
    exp = {4'd0, 1'b1, 1'b1, 1'b1, 8'd2};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL loss_err1: got %h want %h", obs, exp);
    end
    send(4'b0101);
    exp = {4'd6, 1'b1, 1'b1, 1'b1, 8'd3};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL loss_err2: got %h want %h", obs, exp);
    end
    send(4'b1111);
    exp = {4'd10, 1'b1, 1'b1, 1'b0, 8'd4};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL loss_err3_unlock: got %h want %h", obs, exp);
    end
    send(4'b1110);
    exp = {4'd11, 1'b1, 1'b0, 1'b1, 8'd4};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL relock: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_repeat_gaps();
    logic [14:0] exp;
    send(4'b0001);  // 11 -> 1: illegal, err_count 5
    send(4'b0011);  // 1 -> 2: legal
    for (int k = 0; k < 4; k++) begin
      send(4'b0011);
      exp = {4'd2, 1'b1, 1'b0, 1'b1, 8'd5};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL repeat_valid[%0d]: got %h want %h", k, obs, exp);
      end
      gap();
      exp = {4'd2, 1'b0, 1'b0, 1'b1, 8'd5};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL repeat_gap[%0d]: got %h want %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] exp;
    do_reset();
    send(4'b0000);
    send(4'b0010);
    send(4'b0111);
    exp = {4'd5, 1'b1, 1'b1, 1'b1, 8'd2};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL pre_reset_errs: got %h want %h", obs, exp);
    end
    @(negedge clk);
    gray_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp = 15'd0;
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL async_reset_clear: got %h want %h", obs, exp);
    end
    @(negedge clk);
    rst = 1'b0;
    send(4'b1111);
    exp = {4'd10, 1'b1, 1'b0, 1'b1, 8'd0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL post_reset_lock: got %h want %h", obs, exp);
    end
    send(4'b1110);
    exp = {4'd11, 1'b1, 1'b0, 1'b1, 8'd0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL post_reset_step: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_down_step();
    logic [14:0] exp;
    do_reset();
    send(4'b0011);
    send(4'b0001);
`ifdef GRAY_DEC_BIDIR_EN
    exp = {4'd1, 1'b1, 1'b0, 1'b1, 8'd0};
    n_checks++;
    if (dir !== 1'b0) begin
      n_fail++;
      $display("FAIL down_dir: got %b want 0", dir);
    end
    send(4'b0011);
    n_checks++;
    if (dir !== 1'b1) begin
      n_fail++;
      $display("FAIL up_dir: got %b want 1", dir);
    end
    exp = {4'd2, 1'b1, 1'b0, 1'b1, 8'd0};
`else
    exp = {4'd1, 1'b1, 1'b1, 1'b1, 8'd1};
`endif
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL down_step: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_saturate();
    logic [14:0] exp;
    do_reset();
    send(4'b0000);
    // Illegal jump then repeat keeps the miss streak at one, so lock holds.
    for (int k = 0; k < 130; k++) begin
      send(4'b1100);
      send(4'b1100);
      send(4'b0000);
      send(4'b0000);
    end
    exp = {4'd0, 1'b1, 1'b0, 1'b1, 8'hFF};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL err_saturate: got %h want %h", obs, exp);
    end
    send(4'b1100);
    exp = {4'd8, 1'b1, 1'b1, 1'b1, 8'hFF};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL err_no_wrap: got %h want %h", obs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_step_error();
    test_loss();
    test_repeat_gaps();
    test_async_reset();
    test_down_step();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
